// File: rtl/config_register_framed_scan.sv
// Serial configuration register: static/dynamic shift chains with
// bit-count-checked commit, sticky framing error, scan mode and mux decoder.
module config_register_framed_scan #(
    parameter int                    SIZESRSTAT  = 88,
    parameter int                    SIZESRDYN   = 16,
    parameter int                    SIZEADDRMUX = 7,
    parameter int                    STG2_BITS   = 4,
    parameter int                    STG1_BITS   = 2,
    parameter logic [SIZESRSTAT-1:0] STAT_DEF    = '0,
    parameter logic [SIZESRDYN-1:0]  DYN_DEF     = 16'h4000,
    parameter int                    DWELL_CYC   = 1024
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          SEL,
    input  logic                          SHIFT_EN,
    input  logic                          SDI,
    output logic                          SDO,
    input  logic                          ERR_CLR,
    input  logic                          SCAN_EN,
    output logic [SIZESRSTAT-1:0]         STATCNF,
    output logic [SIZESRDYN-1:0]          DYNCNF,
    output logic [1:0]                    CNF_UPD,
    output logic                          CNF_ERR,
    output logic [(2**SIZEADDRMUX)-1:0]   AMUXSEL,
    output logic [(2**STG2_BITS)-1:0]     STG2_EN,
    output logic [(2**STG1_BITS)-1:0]     STG1_EN,
    output logic                          ref_elec_en,
    output logic [SIZEADDRMUX-1:0]        ADDR_CUR,
    output logic                          SCAN_WRAP
);

    localparam int NADDR = 2 ** SIZEADDRMUX;
    localparam int NSTG2 = 2 ** STG2_BITS;
    localparam int NSTG1 = 2 ** STG1_BITS;
    localparam int LMAX  = ((SIZESRSTAT > SIZESRDYN) ? SIZESRSTAT : SIZESRDYN) + 1;
    localparam int CW    = $clog2(LMAX + 1);
    localparam int DW    = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;

    localparam logic [CW-1:0] STAT_LEN = CW'(SIZESRSTAT);
    localparam logic [CW-1:0] DYN_LEN  = CW'(SIZESRDYN);
    localparam logic [CW-1:0] STAT_SAT = CW'(SIZESRSTAT + 1);
    localparam logic [CW-1:0] DYN_SAT  = CW'(SIZESRDYN + 1);
    localparam logic [DW-1:0] DWELL_TC = DW'(DWELL_CYC - 1);

    logic [SIZESRSTAT-1:0]  stat_sr_q, stat_sr_d;
    logic [SIZESRDYN-1:0]   dyn_sr_q, dyn_sr_d;
    logic [SIZESRSTAT-1:0]  stat_cnf_q, stat_cnf_d;
    logic [SIZESRDYN-1:0]   dyn_cnf_q, dyn_cnf_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   sel_q;
    logic [1:0]             upd_q, upd_d;
    logic                   err_q, err_d;
    logic [DW-1:0]          dwell_q, dwell_d;
    logic [SIZEADDRMUX-1:0] scan_q, scan_d;
    logic                   wrap_q, wrap_d;
    logic [NADDR-1:0]       amux_q, amux_d;
    logic [NSTG2-1:0]       stg2_q, stg2_d;
    logic [NSTG1-1:0]       stg1_q, stg1_d;
    logic                   ref_q, ref_d;

    logic                   sel_edge;
    logic                   frame_ok;
    logic [CW-1:0]          cnt_sat;
    logic [SIZEADDRMUX-1:0] addr_cur;
    logic                   mux_en;

    assign sel_edge = SEL ^ sel_q;
    assign frame_ok = sel_q ? (cnt_q == DYN_LEN) : (cnt_q == STAT_LEN);
    assign cnt_sat  = SEL ? DYN_SAT : STAT_SAT;
    assign addr_cur = SCAN_EN ? scan_q : dyn_cnf_q[SIZEADDRMUX-1:0];
    assign mux_en   = dyn_cnf_q[SIZEADDRMUX];

    // Only the chain picked by the live SEL shifts, even in an edge cycle.
    always_comb begin
        stat_sr_d = stat_sr_q;
        dyn_sr_d  = dyn_sr_q;
        if (SHIFT_EN) begin
            if (SEL) begin
                dyn_sr_d = {dyn_sr_q[SIZESRDYN-2:0], SDI};
            end else begin
                stat_sr_d = {stat_sr_q[SIZESRSTAT-2:0], SDI};
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (sel_edge) begin
            cnt_d = {{(CW-1){1'b0}}, SHIFT_EN};
        end else if (SHIFT_EN && (cnt_q < cnt_sat)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A new framing error takes priority over a clear in the same cycle.
    always_comb begin
        stat_cnf_d = stat_cnf_q;
        dyn_cnf_d  = dyn_cnf_q;
        upd_d      = 2'b00;
        err_d      = err_q & ~ERR_CLR;
        if (sel_edge) begin
            if (!frame_ok) begin
                err_d = 1'b1;
            end else if (sel_q) begin
                dyn_cnf_d = dyn_sr_q;
                upd_d[1]  = 1'b1;
            end else begin
                stat_cnf_d = stat_sr_q;
                upd_d[0]   = 1'b1;
            end
        end
    end

    always_comb begin
        dwell_d = '0;
        scan_d  = '0;
        wrap_d  = 1'b0;
        if (SCAN_EN) begin
            dwell_d = dwell_q + 1'b1;
            scan_d  = scan_q;
            if (dwell_q == DWELL_TC) begin
                dwell_d = '0;
                scan_d  = scan_q + 1'b1;
                wrap_d  = &scan_q;
            end
        end
    end

    always_comb begin
        amux_d = {{(NADDR-1){1'b0}}, mux_en} << addr_cur;
        stg2_d = {{(NSTG2-1){1'b0}}, mux_en}
                 << addr_cur[SIZEADDRMUX-1 -: STG2_BITS];
        stg1_d = {{(NSTG1-1){1'b0}}, mux_en}
                 << addr_cur[SIZEADDRMUX-1 -: STG1_BITS];
        ref_d  = ~mux_en & (|addr_cur);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_sr_q  <= STAT_DEF;
            dyn_sr_q   <= DYN_DEF;
            stat_cnf_q <= STAT_DEF;
            dyn_cnf_q  <= DYN_DEF;
            cnt_q      <= '0;
            sel_q      <= SEL;
            upd_q      <= 2'b00;
            err_q      <= 1'b0;
            dwell_q    <= '0;
            scan_q     <= '0;
            wrap_q     <= 1'b0;
            amux_q     <= '0;
            stg2_q     <= '0;
            stg1_q     <= '0;
            ref_q      <= 1'b0;
        end else begin
            stat_sr_q  <= stat_sr_d;
            dyn_sr_q   <= dyn_sr_d;
            stat_cnf_q <= stat_cnf_d;
            dyn_cnf_q  <= dyn_cnf_d;
            cnt_q      <= cnt_d;
            sel_q      <= SEL;
            upd_q      <= upd_d;
            err_q      <= err_d;
            dwell_q    <= dwell_d;
            scan_q     <= scan_d;
            wrap_q     <= wrap_d;
            amux_q     <= amux_d;
            stg2_q     <= stg2_d;
            stg1_q     <= stg1_d;
            ref_q      <= ref_d;
        end
    end

    assign SDO         = SEL ? dyn_sr_q[SIZESRDYN-1] : stat_sr_q[SIZESRSTAT-1];
    assign STATCNF     = stat_cnf_q;
    assign DYNCNF      = dyn_cnf_q;
    assign CNF_UPD     = upd_q;
    assign CNF_ERR     = err_q;
    assign AMUXSEL     = amux_q;
    assign STG2_EN     = stg2_q;
    assign STG1_EN     = stg1_q;
    assign ref_elec_en = ref_q;
    assign ADDR_CUR    = addr_cur;
    assign SCAN_WRAP   = wrap_q;

endmodule

// File: tb/tb_config_register_framed_scan.sv
// Randomized bench for config_register_framed_scan against a behavioural model.
module tb_config_register_framed_scan;

    localparam int NS = 88;
    localparam int ND = 16;
    localparam int DWELL = 4;

    logic         CLK = 1'b0;
    logic         RST, SEL, SHIFT_EN, SDI, ERR_CLR, SCAN_EN;
    logic         SDO;
    logic [87:0]  STATCNF;
    logic [15:0]  DYNCNF;
    logic [1:0]   CNF_UPD;
    logic         CNF_ERR;
    logic [127:0] AMUXSEL;
    logic [15:0]  STG2_EN;
    logic [3:0]   STG1_EN;
    logic         ref_elec_en;
    logic [6:0]   ADDR_CUR;
    logic         SCAN_WRAP;

    always #5 CLK = ~CLK;

    config_register_framed_scan #(.DWELL_CYC(DWELL)) dut (
        .CLK(CLK), .RST(RST), .SEL(SEL), .SHIFT_EN(SHIFT_EN), .SDI(SDI),
        .SDO(SDO), .ERR_CLR(ERR_CLR), .SCAN_EN(SCAN_EN),
        .STATCNF(STATCNF), .DYNCNF(DYNCNF), .CNF_UPD(CNF_UPD),
        .CNF_ERR(CNF_ERR), .AMUXSEL(AMUXSEL), .STG2_EN(STG2_EN),
        .STG1_EN(STG1_EN), .ref_elec_en(ref_elec_en),
        .ADDR_CUR(ADDR_CUR), .SCAN_WRAP(SCAN_WRAP)
    );

    // Reference model state
    logic [87:0]  m_ssr, m_scnf;
    logic [15:0]  m_dsr, m_dcnf;
    int           m_bits, m_dwell, m_scan;
    logic         m_lsel, m_err, m_wrap, m_ref;
    logic [1:0]   m_upd;
    logic [127:0] m_amux;
    logic [15:0]  m_stg2;
    logic [3:0]   m_stg1;

    int n_chk = 0;
    int n_pass = 0;
    int wraps = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_step();
        logic sel_chg;
        logic en;
        int   a;
        if (RST) begin
            m_ssr = '0; m_scnf = '0;
            m_dsr = 16'h4000; m_dcnf = 16'h4000;
            m_bits = 0; m_dwell = 0; m_scan = 0;
            m_lsel = SEL; m_err = 0; m_wrap = 0; m_upd = 0;
            m_amux = '0; m_stg2 = '0; m_stg1 = '0; m_ref = 0;
            return;
        end
        en = m_dcnf[7];
        a  = SCAN_EN ? m_scan : int'(m_dcnf[6:0]);
        m_amux = '0; m_stg2 = '0; m_stg1 = '0;
        if (en) begin
            m_amux[a] = 1'b1;
            m_stg2[a / 8] = 1'b1;
            m_stg1[a / 32] = 1'b1;
        end
        m_ref = !en && (a != 0);
        sel_chg = (SEL != m_lsel);
        m_upd = 2'b00;
        if (ERR_CLR) m_err = 1'b0;
        if (sel_chg) begin
            if (!m_lsel) begin
                if (m_bits == NS) begin m_scnf = m_ssr; m_upd = 2'b01; end
                else m_err = 1'b1;
            end else begin
                if (m_bits == ND) begin m_dcnf = m_dsr; m_upd = 2'b10; end
                else m_err = 1'b1;
            end
        end
        m_lsel = SEL;
        if (SHIFT_EN) begin
            if (SEL) m_dsr = {m_dsr[14:0], SDI};
            else m_ssr = {m_ssr[86:0], SDI};
        end
        if (sel_chg) m_bits = SHIFT_EN ? 1 : 0;
        else if (SHIFT_EN && m_bits < (SEL ? ND : NS) + 1) m_bits++;
        m_wrap = 1'b0;
        if (!SCAN_EN) begin
            m_dwell = 0; m_scan = 0;
        end else begin
            m_dwell++;
            if (m_dwell == DWELL) begin
                m_dwell = 0;
                m_wrap = (m_scan == 127);
                m_scan = (m_scan + 1) % 128;
            end
        end
    endtask

    task automatic check_all();
        chk("SDO", SDO, SEL ? m_dsr[15] : m_ssr[87]);
        chk("STATCNF", STATCNF, m_scnf);
        chk("DYNCNF", DYNCNF, m_dcnf);
        chk("CNF_UPD", CNF_UPD, m_upd);
        chk("CNF_ERR", CNF_ERR, m_err);
        chk("AMUXSEL", AMUXSEL, m_amux);
        chk("STG2_EN", STG2_EN, m_stg2);
        chk("STG1_EN", STG1_EN, m_stg1);
        chk("ref_elec_en", ref_elec_en, m_ref);
        chk("ADDR_CUR", ADDR_CUR, SCAN_EN ? 7'(m_scan) : m_dcnf[6:0]);
        chk("SCAN_WRAP", SCAN_WRAP, m_wrap);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        check_all();
        if (SCAN_WRAP) wraps++;
    endtask

    task automatic send(input int n, input logic [127:0] d);
        for (int k = n - 1; k >= 0; k--) begin
            SHIFT_EN = 1'b1;
            SDI = d[k];
            tick();
        end
        SHIFT_EN = 1'b0;
        SDI = 1'b0;
    endtask

    initial begin
        logic [127:0] d;
        RST = 1; SEL = 0; SHIFT_EN = 0; SDI = 0; ERR_CLR = 0; SCAN_EN = 0;
        tick();
        RST = 0;
        tick(); tick();
        chk("rst_statcnf", STATCNF, 88'h0);
        chk("rst_dyncnf", DYNCNF, 16'h4000);
        chk("rst_amux", AMUXSEL, 128'h0);
        chk("rst_ref", ref_elec_en, 1'b0);
        chk("rst_err", CNF_ERR, 1'b0);

        // Dynamic frame 00A5 -> address 37 enabled
        RST = 1; SEL = 1; tick(); RST = 0;
        send(16, 128'h00A5);
        SEL = 0; tick();
        chk("dyn_upd", CNF_UPD, 2'b10);
        chk("dyn_cnf", DYNCNF, 16'h00A5);
        tick();
        chk("dyn_upd_drop", CNF_UPD, 2'b00);
        chk("dec_amux37", AMUXSEL, 128'h1 << 37);
        chk("dec_stg2", STG2_EN, 16'h0010);
        chk("dec_stg1", STG1_EN, 4'h2);

        // Short static frame -> framing error
        d = {$urandom, $urandom, $urandom, $urandom};
        send(87, d);
        SEL = 1; tick();
        chk("short_err", CNF_ERR, 1'b1);
        chk("short_upd", CNF_UPD, 2'b00);
        chk("short_stat", STATCNF, 88'h0);
        ERR_CLR = 1; tick(); ERR_CLR = 0;
        chk("err_clr", CNF_ERR, 1'b0);

        // Disabled mux, nonzero address -> reference electrode
        send(16, 128'h0005);
        SEL = 0; tick(); tick();
        chk("ref_amux", AMUXSEL, 128'h0);
        chk("ref_en", ref_elec_en, 1'b1);

        // Scan mode with enabled mux at address 5
        SEL = 1; tick();
        send(16, 128'h0085);
        SEL = 0; tick(); tick();
        ERR_CLR = 1; tick(); ERR_CLR = 0;
        SCAN_EN = 1; wraps = 0;
        repeat (520) tick();
        chk("scan_wraps", wraps, 1);
        SCAN_EN = 0; tick();
        chk("scan_off_addr", ADDR_CUR, 7'd5);
        tick();
        chk("scan_off_amux", AMUXSEL, 128'h1 << 5);

        // Reset mid static frame, then a clean 88-bit frame
        d = {$urandom, $urandom, $urandom, $urandom};
        send(40, d);
        RST = 1; tick(); RST = 0;
        chk("midrst_stat", STATCNF, 88'h0);
        chk("midrst_dyn", DYNCNF, 16'h4000);
        d = {$urandom, $urandom, $urandom, $urandom};
        send(88, d);
        SEL = 1; tick();
        chk("full_upd", CNF_UPD, 2'b01);
        chk("full_stat", STATCNF, d[87:0]);
        chk("full_err", CNF_ERR, 1'b0);

        // Random frames: correct, short, long, saturating, arbitrary lengths
        for (int f = 0; f < 60; f++) begin
            int r, n, len;
            logic s;
            s = 1'($urandom_range(0, 1));
            len = s ? ND : NS;
            r = int'($urandom_range(0, 9));
            n = (r < 6) ? len : (r == 6) ? len - 1 : (r == 7) ? len + 1 :
                (r == 8) ? len + 3 : int'($urandom_range(0, len));
            d = {$urandom, $urandom, $urandom, $urandom};
            SCAN_EN = ($urandom_range(0, 2) == 0);
            SEL = s;
            for (int k = n - 1; k >= 0; k--) begin
                while ($urandom_range(0, 3) == 0) begin
                    SHIFT_EN = 0;
                    ERR_CLR = ($urandom_range(0, 7) == 0);
                    tick();
                end
                SHIFT_EN = 1;
                SDI = d[k % 128];
                ERR_CLR = ($urandom_range(0, 7) == 0);
                RST = ($urandom_range(0, 299) == 0);
                tick();
                RST = 0;
            end
            SHIFT_EN = 0; ERR_CLR = 0;
            tick(); tick();
        end
        SEL = ~SEL; tick(); tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
